// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: descriptor layout, FIFO entry type and FSM states shared by
// the DMA job scheduler and its descriptor FIFO.
package dma_sched_pkg;

    localparam int DESC_W   = 29;
    localparam int RW_BIT   = 28;
    localparam int SRC_LSB  = 20;
    localparam int DST_LSB  = 12;
    localparam int MEM1_LSB = 6;
    localparam int MEM2_LSB = 0;
    localparam int ENTRY_W  = DESC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_COMPLETE
    } sched_state_t;

    // One queued job: the requester that owns it plus its descriptor.
    typedef struct packed {
        logic              id;
        logic [DESC_W-1:0] desc;
    } sched_entry_t;

    function automatic logic desc_rw(input logic [DESC_W-1:0] d);
        return d[RW_BIT];
    endfunction

    function automatic logic [7:0] desc_src(input logic [DESC_W-1:0] d);
        return d[SRC_LSB +: 8];
    endfunction

    function automatic logic [7:0] desc_dst(input logic [DESC_W-1:0] d);
        return d[DST_LSB +: 8];
    endfunction

    function automatic logic [5:0] desc_mem1(input logic [DESC_W-1:0] d);
        return d[MEM1_LSB +: 6];
    endfunction

    function automatic logic [5:0] desc_mem2(input logic [DESC_W-1:0] d);
        return d[MEM2_LSB +: 6];
    endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// dma_desc_fifo: small synchronous FIFO holding queued DMA jobs.
// Registered occupancy count; push and pop in the same cycle keep the count.
module dma_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic                     clk_h,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    // Ignore illegal requests so the pointers can never lap each other.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_h) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/dma_scheduler.sv
// dma_scheduler: round-robin job scheduler in front of the dma block.
// Two requesters push descriptors into a FIFO; jobs are launched one at a
// time and completion is reported back to the owning requester.
// Optional: define DMA_SCHED_TIMEOUT_EN to end a stuck WAIT after TIMEOUT
// cycles with done_err=1.
module dma_scheduler
    import dma_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_h,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic [DESC_W-1:0]      req0_desc,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [DESC_W-1:0]      req1_desc,
    output logic                   req1_ready,
    output logic                   done_valid,
    output logic                   done_id,
    output logic                   done_err,
    output logic                   dma_enable,
    output logic                   dma_rw,
    output logic [7:0]             dma_sdram_src,
    output logic [7:0]             dma_sdram_dst,
    output logic [5:0]             dma_mem1_addr,
    output logic [5:0]             dma_mem2_addr,
    input  logic                   dma_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] q_count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("dma_scheduler: DEPTH must be a power of two >= 2, TIMEOUT >= 1");
    end

    sched_state_t state_q;
    logic         rr_q, rr_d;
    logic         grant0, grant1;
    logic         fifo_full, fifo_empty, fifo_pop;
    sched_entry_t push_entry, head;

    logic         dma_enable_q, dma_rw_q, done_valid_q, done_id_q;
    logic [7:0]   src_q, dst_q;
    logic [5:0]   mem1_q, mem2_q;

    // Arbitration: a lone valid port always wins, ties go to rr; a full FIFO
    // refuses both, even in a cycle that pops.
    assign grant0 = !fifo_full && req0_valid && (!req1_valid || !rr_q);
    assign grant1 = !fifo_full && req1_valid && (!req0_valid ||  rr_q);
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign push_entry.id   = grant1;
    assign push_entry.desc = grant1 ? req1_desc : req0_desc;

    // Next round-robin pointer: point away from whichever port was granted.
    always_comb begin
        rr_d = rr_q;
        if (grant0)      rr_d = 1'b1;
        else if (grant1) rr_d = 1'b0;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_h) begin
        if (!rst_n) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end

    // The head is retired in the COMPLETE cycle, so it stays valid for the
    // whole job and supplies done_id.
    assign fifo_pop = (state_q == S_COMPLETE);

    dma_desc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_h   (clk_h),
        .rst_n   (rst_n),
        .push_i  (grant0 || grant1),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (q_count)
    );

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_hit;
    logic             done_err_q;

    // The count reaches TIMEOUT on the WAIT cycle where it currently holds
    // TIMEOUT-1; that cycle is the limit.
    assign tmo_hit  = (tmo_cnt_q == TMO_LAST);
    assign done_err = done_err_q;

    // WAIT-cycle counter, cleared on every launch.
    always_ff @(posedge clk_h) begin
        if (!rst_n)                    tmo_cnt_q <= '0;
        else if (state_q == S_LAUNCH)  tmo_cnt_q <= '0;
        else if (state_q == S_WAIT)    tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
`else
    assign done_err = 1'b0;
`endif

    // Job FSM with registered pulses; DMA parameters are captured from the
    // head on IDLE->LAUNCH and then held until the next launch.
    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dma_enable_q <= 1'b0;
            done_valid_q <= 1'b0;
            done_id_q    <= 1'b0;
            dma_rw_q     <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            mem1_q       <= '0;
            mem2_q       <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
            done_err_q   <= 1'b0;
`endif
        end else begin
            dma_enable_q <= 1'b0;
            done_valid_q <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
            done_err_q   <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_q      <= S_LAUNCH;
                        dma_enable_q <= 1'b1;
                        dma_rw_q     <= desc_rw(head.desc);
                        src_q        <= desc_src(head.desc);
                        dst_q        <= desc_dst(head.desc);
                        mem1_q       <= desc_mem1(head.desc);
                        mem2_q       <= desc_mem2(head.desc);
                    end
                end
                S_LAUNCH: state_q <= S_WAIT;
                S_WAIT: begin
                    if (dma_done) begin
                        state_q      <= S_COMPLETE;
                        done_valid_q <= 1'b1;
                        done_id_q    <= head.id;
                    end
`ifdef DMA_SCHED_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_q      <= S_COMPLETE;
                        done_valid_q <= 1'b1;
                        done_id_q    <= head.id;
                        done_err_q   <= 1'b1;
                    end
`endif
                end
                S_COMPLETE: state_q <= S_IDLE;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    assign dma_enable    = dma_enable_q;
    assign done_valid    = done_valid_q;
    assign done_id       = done_id_q;
    assign dma_rw        = dma_rw_q;
    assign dma_sdram_src = src_q;
    assign dma_sdram_dst = dst_q;
    assign dma_mem1_addr = mem1_q;
    assign dma_mem2_addr = mem2_q;
    assign busy          = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dma_scheduler.sv
// tb_dma_scheduler: directed scoreboard bench for dma_scheduler.
// Expected jobs are queued on acceptance and checked at launch/completion.
// The timeout scenario runs only when DMA_SCHED_TIMEOUT_EN is defined.
module tb_dma_scheduler;
    import dma_sched_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic              clk_h = 1'b0;
    logic              rst_n;
    logic              r0v, r1v, dd;
    logic [DESC_W-1:0] r0d, r1d;
    logic              req0_ready, req1_ready;
    logic              done_valid, done_id, done_err, dma_enable, dma_rw, busy;
    logic [7:0]        dma_sdram_src, dma_sdram_dst;
    logic [5:0]        dma_mem1_addr, dma_mem2_addr;
    logic [$clog2(DEPTH):0] q_count;

    always #5 clk_h = ~clk_h;

    dma_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_h(clk_h), .rst_n(rst_n),
        .req0_valid(r0v), .req0_desc(r0d), .req0_ready(req0_ready),
        .req1_valid(r1v), .req1_desc(r1d), .req1_ready(req1_ready),
        .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
        .dma_enable(dma_enable), .dma_rw(dma_rw),
        .dma_sdram_src(dma_sdram_src), .dma_sdram_dst(dma_sdram_dst),
        .dma_mem1_addr(dma_mem1_addr), .dma_mem2_addr(dma_mem2_addr),
        .dma_done(dd), .busy(busy), .q_count(q_count)
    );

    int           n_checks = 0, n_fail = 0, cyc_n = 0;
    int           m_cnt = 0;
    logic         m_rr = 1'b0;
    sched_entry_t exp_q[$];
    sched_entry_t cur;
    logic         have_cur = 1'b0, job_open = 1'b0, exp_err = 1'b0;
    int           n_launch = 0, n_done = 0, launch_cyc = 0, done_cyc = -100;
    logic         grant_log[$];
    logic         done_log[$];

    function automatic logic [DESC_W-1:0] mk(input logic rw, input logic [7:0] s,
                                             input logic [7:0] d, input logic [5:0] m1,
                                             input logic [5:0] m2);
        return {rw, s, d, m1, m2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Evaluate the current cycle against the model, then advance one clock.
    task automatic cyc();
        logic g0, g1, full;
        #1;
        full = (m_cnt == DEPTH);
        g0 = !full && r0v && (!r1v || !m_rr);
        g1 = !full && r1v && (!r0v ||  m_rr);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("q_count", q_count, m_cnt);
        if (dma_enable) begin
            chk("launch_has_job", exp_q.size() != 0, 1);
            chk("launch_while_idle", job_open, 0);
            if (n_done > 0) chk("launch_gap", (cyc_n - done_cyc) >= 2, 1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            have_cur = 1'b1;
            job_open = 1'b1;
            launch_cyc = cyc_n;
            n_launch++;
        end
        chk("dma_rw",   dma_rw,        have_cur ? 32'(cur.desc[28])    : 0);
        chk("dma_src",  dma_sdram_src, have_cur ? 32'(cur.desc[27:20]) : 0);
        chk("dma_dst",  dma_sdram_dst, have_cur ? 32'(cur.desc[19:12]) : 0);
        chk("dma_mem1", dma_mem1_addr, have_cur ? 32'(cur.desc[11:6])  : 0);
        chk("dma_mem2", dma_mem2_addr, have_cur ? 32'(cur.desc[5:0])   : 0);
        if (done_valid) begin
            chk("done_has_job", job_open, 1);
            chk("done_id", done_id, cur.id);
            chk("done_err", done_err, exp_err);
            done_log.push_back(done_id);
            job_open = 1'b0;
            done_cyc = cyc_n;
            n_done++;
        end
        if (g0) begin exp_q.push_back('{id: 1'b0, desc: r0d}); grant_log.push_back(1'b0); end
        if (g1) begin exp_q.push_back('{id: 1'b1, desc: r1d}); grant_log.push_back(1'b1); end
        m_cnt = m_cnt + int'(g0) + int'(g1) - int'(done_valid);
        if (g0) m_rr = 1'b1;
        else if (g1) m_rr = 1'b0;
        @(posedge clk_h); #1;
        cyc_n++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; r0v = 1'b0; r1v = 1'b0; dd = 1'b0;
        @(posedge clk_h); #1;
        cyc_n++;
        rst_n = 1'b1;
        m_cnt = 0; m_rr = 1'b0; exp_q.delete();
        have_cur = 1'b0; job_open = 1'b0; exp_err = 1'b0;
    endtask

    task automatic run_until_launch(input int budget);
        int n0, k;
        n0 = n_launch; k = 0;
        while (n_launch == n0 && k < budget) begin cyc(); k++; end
        chk("launch_wait", n_launch != n0, 1);
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while ((m_cnt != 0 || busy || job_open) && k < budget) begin cyc(); k++; end
        chk("drain_q_count", q_count, 0);
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        int t0;
        logic exp_ids [3];
        logic exp_gr [5];
        r0d = '0; r1d = '0;

        // Reset state
        rst_n = 1'b0; r0v = 1'b0; r1v = 1'b0; dd = 1'b0;
        repeat (2) @(posedge clk_h);
        #1;
        chk("rst_dma_enable", dma_enable, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_done_err", done_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_fields", {dma_rw, dma_sdram_src, dma_sdram_dst, dma_mem1_addr, dma_mem2_addr}, 0);
        rst_n = 1'b1;

        // Single job, dma_done stray in IDLE and LAUNCH must be ignored
        dd = 1'b1; cyc(); dd = 1'b0;
        t0 = cyc_n;
        r0v = 1'b1; r0d = mk(1'b0, 8'h10, 8'h13, 6'd5, 6'd9);
        cyc();
        r0v = 1'b0;
        cyc();
        dd = 1'b1; cyc(); dd = 1'b0;
        chk("launch_latency", launch_cyc - t0, 2);
        repeat (5) cyc();
        chk("busy_in_wait", busy, 1);
        dd = 1'b1; cyc(); dd = 1'b0;
        cyc();
        chk("done_latency", done_cyc - launch_cyc, 7);
        cyc();
        chk("idle_busy", busy, 0);
        chk("idle_hold_src", dma_sdram_src, 8'h10);

        // Contention from reset: alternating grants, fill, full+pop
        do_reset();
        grant_log.delete();
        r0v = 1'b1; r1v = 1'b1;
        for (int i = 0; i < 10; i++) begin
            r0d = DESC_W'($urandom); r1d = DESC_W'($urandom);
            cyc();
        end
        chk("fill_q_count", q_count, DEPTH);
        dd = 1'b1; cyc(); dd = 1'b0;
        chk("full_pop_ready0", req0_ready, 0);
        chk("full_pop_ready1", req1_ready, 0);
        for (int i = 0; i < 3; i++) begin
            r0d = DESC_W'($urandom); r1d = DESC_W'($urandom);
            cyc();
        end
        chk("refill_q_count", q_count, DEPTH);
        exp_gr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        chk("grant_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk($sformatf("grant_%0d", i), grant_log[i], exp_gr[i]);
        r0v = 1'b0; r1v = 1'b0;
        dd = 1'b1;
        run_until_idle(200);
        dd = 1'b0;

        // Ordering: A(port1), B(port0), C(port1)
        do_reset();
        done_log.delete();
        r1v = 1'b1; r1d = mk(1'b1, 8'hA0, 8'hA7, 6'd1, 6'd2); cyc(); r1v = 1'b0;
        r0v = 1'b1; r0d = mk(1'b0, 8'hB0, 8'hB3, 6'd3, 6'd4); cyc(); r0v = 1'b0;
        r1v = 1'b1; r1d = mk(1'b1, 8'hC0, 8'hCF, 6'd62, 6'd63); cyc(); r1v = 1'b0;
        repeat (3) cyc();
        dd = 1'b1;
        run_until_idle(100);
        dd = 1'b0;
        exp_ids = '{1'b1, 1'b0, 1'b1};
        chk("order_count", done_log.size(), 3);
        for (int i = 0; i < 3 && i < done_log.size(); i++)
            chk($sformatf("order_%0d", i), done_log[i], exp_ids[i]);

        // Reset during WAIT with more jobs queued
        do_reset();
        r0v = 1'b1; r0d = mk(1'b1, 8'h55, 8'h66, 6'd7, 6'd8); cyc();
        r0d = mk(1'b0, 8'h11, 8'h22, 6'd9, 6'd10); cyc();
        r0d = mk(1'b1, 8'h33, 8'h44, 6'd11, 6'd12); cyc();
        r0v = 1'b0;
        repeat (2) cyc();
        chk("pre_rst_busy", busy, 1);
        do_reset();
        chk("post_rst_enable", dma_enable, 0);
        chk("post_rst_done", done_valid, 0);
        chk("post_rst_q_count", q_count, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_fields", {dma_rw, dma_sdram_src, dma_sdram_dst, dma_mem1_addr, dma_mem2_addr}, 0);
        dd = 1'b1;
        repeat (4) cyc();
        dd = 1'b0;
        chk("post_rst_no_launch", busy, 0);

`ifdef DMA_SCHED_TIMEOUT_EN
        // Timeout with no dma_done
        do_reset();
        r1v = 1'b1; r1d = mk(1'b0, 8'h77, 8'h78, 6'd13, 6'd14); cyc(); r1v = 1'b0;
        run_until_launch(10);
        exp_err = 1'b1;
        t0 = n_done;
        for (int k = 0; k < 20 && n_done == t0; k++) cyc();
        chk("tmo_done_seen", n_done != t0, 1);
        chk("tmo_latency", done_cyc - launch_cyc, TIMEOUT + 1);
        exp_err = 1'b0;
        cyc();
        // dma_done on the limit cycle wins
        r0v = 1'b1; r0d = mk(1'b1, 8'h88, 8'h89, 6'd15, 6'd16); cyc(); r0v = 1'b0;
        run_until_launch(10);
        repeat (TIMEOUT - 1) cyc();
        dd = 1'b1; cyc(); dd = 1'b0;
        cyc();
        chk("tmo_race_latency", done_cyc - launch_cyc, TIMEOUT + 1);
        run_until_idle(20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
